// File: rtl/id_ex_operand_stage_pkg.sv
// Shared MIPS definitions: ALU control codes, opcode/funct constants and
// forward-select encodings used by the E stage and later stage control.
package mips_defs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_MOVZ = 4'd3
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_AO_M  = 2'd1,
    FWD_WD_W  = 2'd2,
    FWD_PC8_M = 2'd3
  } fwd_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] fwd_mux(input fwd_sel_e sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] ao_m,
                                          input logic [31:0] wd_w,
                                          input logic [31:0] pc8_m);
    unique case (sel)
      FWD_AO_M:  return ao_m;
      FWD_WD_W:  return wd_w;
      FWD_PC8_M: return pc8_m;
      default:   return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_e_ctrl_decode.sv
// Combinational decode of an E-stage instruction into ALU control,
// operand-B/A steering and the destination register.
module e_ctrl_decode
  import mips_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  input  logic [5:0] funct_i,
  output alu_ctrl_e  alu_ctrl_o,
  output logic       imm_sel_o,
  output logic       srca_zero_o,
  output logic       movz_o,
  output logic [4:0] wa_o,
  output logic       we_base_o
);

  always_comb begin
    alu_ctrl_o  = ALU_ADD;
    imm_sel_o   = 1'b0;
    srca_zero_o = 1'b0;
    movz_o      = 1'b0;
    wa_o        = '0;
    unique case (opcode_i)
      OP_RTYPE: begin
        unique case (funct_i)
          FN_ADDU: wa_o = rd_i;
          FN_SUBU: begin
            alu_ctrl_o = ALU_SUB;
            wa_o       = rd_i;
          end
          FN_MOVZ: begin
            alu_ctrl_o = ALU_MOVZ;
            movz_o     = 1'b1;
            wa_o       = rd_i;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        alu_ctrl_o = ALU_OR;
        imm_sel_o  = 1'b1;
        wa_o       = rt_i;
      end
      // imm_E already carries the upper-half shift, so lui is 0 | imm
      OP_LUI: begin
        alu_ctrl_o  = ALU_OR;
        imm_sel_o   = 1'b1;
        srca_zero_o = 1'b1;
        wa_o        = rt_i;
      end
      OP_LW: begin
        imm_sel_o = 1'b1;
        wa_o      = rt_i;
      end
      OP_SW:   imm_sel_o = 1'b1;
      OP_JAL:  wa_o = 5'd31;
      default: ;
    endcase
  end

  assign we_base_o = (wa_o != 5'd0);

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with E-stage forwarding, driving ALU operands,
// ALU control and write-back control for the downstream stages.
module id_ex_operand_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc8_D,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] rt_data_D,
  input  logic [31:0] ext_imm_D,
  input  logic        clr_E,
  input  logic        hold_E,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [31:0] AO_M,
  input  logic [31:0] WD_W,
  input  logic [31:0] pc8_M,
  output logic [31:0] SrcA_E,
  output logic [31:0] SrcB_E,
  output logic [4:0]  Shift_E,
  output logic [3:0]  ALUCtrl,
  output logic [31:0] rt_fwd_E,
  output logic [4:0]  wa_E,
  output logic        reg_we_E,
  output logic [31:0] instr_E,
  output logic [31:0] pc8_E
);

  logic [31:0] instr_q, instr_d, pc8_q, pc8_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc8_d   = pc8_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    if (clr_E) begin
      instr_d = NOP_INSTR;
      pc8_d   = RESET_PC;
      rs_d    = '0;
      rt_d    = '0;
      imm_d   = '0;
      valid_d = 1'b0;
    end else if (!hold_E) begin
      instr_d = instr_D;
      pc8_d   = pc8_D;
      rs_d    = rs_data_D;
      rt_d    = rt_data_D;
      imm_d   = ext_imm_D;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc8_q   <= RESET_PC;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  alu_ctrl_e   alu_ctrl;
  logic        imm_sel, srca_zero, is_movz, we_base;
  logic [31:0] fwd_a;

  e_ctrl_decode u_decode (
    .opcode_i    (instr_q[31:26]),
    .rt_i        (instr_q[20:16]),
    .rd_i        (instr_q[15:11]),
    .funct_i     (instr_q[5:0]),
    .alu_ctrl_o  (alu_ctrl),
    .imm_sel_o   (imm_sel),
    .srca_zero_o (srca_zero),
    .movz_o      (is_movz),
    .wa_o        (wa_E),
    .we_base_o   (we_base)
  );

  assign fwd_a    = fwd_mux(fwd_sel_e'(fwd_a_sel), rs_q, AO_M, WD_W, pc8_M);
  assign rt_fwd_E = fwd_mux(fwd_sel_e'(fwd_b_sel), rt_q, AO_M, WD_W, pc8_M);
  assign SrcA_E   = srca_zero ? '0 : fwd_a;
  assign SrcB_E   = imm_sel ? imm_q : rt_fwd_E;
  assign Shift_E  = instr_q[10:6];
  assign ALUCtrl  = alu_ctrl;
  // movz condition uses the forwarded rt, not the latched copy
  assign reg_we_E = valid_q && we_base && (!is_movz || (rt_fwd_E == 32'h0));
  assign instr_E  = instr_q;
  assign pc8_E    = pc8_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with hand-computed expectations.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, pc8_D, rs_data_D, rt_data_D, ext_imm_D;
  logic        clr_E, hold_E;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] AO_M, WD_W, pc8_M;
  logic [31:0] SrcA_E, SrcB_E, rt_fwd_E, instr_E, pc8_E;
  logic [4:0]  Shift_E, wa_E;
  logic [3:0]  ALUCtrl;
  logic        reg_we_E;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  id_ex_operand_stage #(.RESET_PC(32'h0000_3000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .pc8_D(pc8_D),
    .rs_data_D(rs_data_D), .rt_data_D(rt_data_D), .ext_imm_D(ext_imm_D),
    .clr_E(clr_E), .hold_E(hold_E), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .AO_M(AO_M), .WD_W(WD_W), .pc8_M(pc8_M), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E),
    .Shift_E(Shift_E), .ALUCtrl(ALUCtrl), .rt_fwd_E(rt_fwd_E), .wa_E(wa_E),
    .reg_we_E(reg_we_E), .instr_E(instr_E), .pc8_E(pc8_E)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rtype(input int unsigned rs, input int unsigned rt,
                                        input int unsigned rd, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int unsigned rs,
                                        input int unsigned rt, input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] movz_w;

  initial begin
    reset = 1'b0; clr_E = 1'b0; hold_E = 1'b0;
    fwd_a_sel = 2'd0; fwd_b_sel = 2'd0;
    AO_M = '0; WD_W = '0; pc8_M = '0;
    instr_D = rtype(1, 2, 3, 6'h21); pc8_D = 32'h0000_3008;
    rs_data_D = 32'd7; rt_data_D = 32'd8; ext_imm_D = '0;

    // 1: reset, then first edge after release loads addu
    edge_sample();
    edge_sample();
    check("rst_instr", instr_E, 32'h0);
    check("rst_pc8", pc8_E, 32'h0000_3000);
    check("rst_alu", {28'd0, ALUCtrl}, 32'd0);
    check("rst_wa", {27'd0, wa_E}, 32'd0);
    check("rst_we", {31'd0, reg_we_E}, 32'd0);
    @(negedge clk); reset = 1'b1;
    #1;
    check("prerel_we", {31'd0, reg_we_E}, 32'd0);
    edge_sample();
    check("addu_instr", instr_E, rtype(1, 2, 3, 6'h21));
    check("addu_wa", {27'd0, wa_E}, 32'd3);
    check("addu_we", {31'd0, reg_we_E}, 32'd1);
    check("addu_srca", SrcA_E, 32'd7);
    check("addu_srcb", SrcB_E, 32'd8);
    check("addu_pc8", pc8_E, 32'h0000_3008);

    // 2: subu $4,$5,$6
    @(negedge clk);
    instr_D = rtype(5, 6, 4, 6'h23) | 32'h0000_0140; // shamt field = 5
    rs_data_D = 32'd10; rt_data_D = 32'd3;
    edge_sample();
    check("subu_alu", {28'd0, ALUCtrl}, 32'd1);
    check("subu_srca", SrcA_E, 32'd10);
    check("subu_srcb", SrcB_E, 32'd3);
    check("subu_wa", {27'd0, wa_E}, 32'd4);
    check("subu_we", {31'd0, reg_we_E}, 32'd1);
    check("subu_shift", {27'd0, Shift_E}, 32'd5);

    // 3: ori $7,$0,0xFF then forward AO_M onto A
    @(negedge clk);
    instr_D = itype(6'h0D, 0, 7, 16'h00FF);
    rs_data_D = 32'd0; rt_data_D = 32'h0000_0099; ext_imm_D = 32'h0000_00FF;
    edge_sample();
    check("ori_srca", SrcA_E, 32'd0);
    check("ori_srcb", SrcB_E, 32'h0000_00FF);
    check("ori_alu", {28'd0, ALUCtrl}, 32'd2);
    check("ori_wa", {27'd0, wa_E}, 32'd7);
    fwd_a_sel = 2'd1; AO_M = 32'h0000_1234;
    #1;
    check("ori_fwdA", SrcA_E, 32'h0000_1234);
    check("ori_fwdB", SrcB_E, 32'h0000_00FF);

    // 4: movz $8,$9,$10 with rt=0, then forwarded rt=5, then forwarded 0
    @(negedge clk);
    fwd_a_sel = 2'd0;
    movz_w = rtype(9, 10, 8, 6'h0A);
    instr_D = movz_w; rs_data_D = 32'h55; rt_data_D = 32'd0;
    edge_sample();
    check("movz0_we", {31'd0, reg_we_E}, 32'd1);
    check("movz0_alu", {28'd0, ALUCtrl}, 32'd3);
    check("movz0_wa", {27'd0, wa_E}, 32'd8);
    fwd_b_sel = 2'd2; WD_W = 32'd5;
    #1;
    check("movzW_we", {31'd0, reg_we_E}, 32'd0);
    check("movzW_rt", rt_fwd_E, 32'd5);
    check("movzW_alu", {28'd0, ALUCtrl}, 32'd3);
    fwd_b_sel = 2'd3; pc8_M = 32'd0;
    #1;
    check("movzP_we", {31'd0, reg_we_E}, 32'd1);

    // 5: hold three cycles while D changes, then clr+hold together
    @(negedge clk);
    fwd_b_sel = 2'd0;
    hold_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_D = rtype(1, 2, 20 + i, 6'h21); pc8_D = 32'h4000 + i;
      rs_data_D = 32'd100 + i; rt_data_D = 32'd1;
      edge_sample();
      check("hold_instr", instr_E, movz_w);
      check("hold_srca", SrcA_E, 32'h55);
      @(negedge clk);
    end
    clr_E = 1'b1;
    edge_sample();
    check("clr_instr", instr_E, 32'h0);
    check("clr_pc8", pc8_E, 32'h0000_3000);
    check("clr_we", {31'd0, reg_we_E}, 32'd0);
    check("clr_wa", {27'd0, wa_E}, 32'd0);
    check("clr_srca", SrcA_E, 32'd0);

    // 6: jal then lui $2,0x8000
    @(negedge clk);
    clr_E = 1'b0; hold_E = 1'b0;
    instr_D = {6'h03, 26'h0000C10}; pc8_D = 32'h0000_3010;
    edge_sample();
    check("jal_wa", {27'd0, wa_E}, 32'd31);
    check("jal_we", {31'd0, reg_we_E}, 32'd1);
    check("jal_pc8", pc8_E, 32'h0000_3010);
    @(negedge clk);
    instr_D = itype(6'h0F, 5, 2, 16'h8000);
    rs_data_D = 32'h0000_DEAD; ext_imm_D = 32'h8000_0000;
    edge_sample();
    check("lui_srca", SrcA_E, 32'd0);
    check("lui_srcb", SrcB_E, 32'h8000_0000);
    check("lui_alu", {28'd0, ALUCtrl}, 32'd2);
    check("lui_wa", {27'd0, wa_E}, 32'd2);

    // sw with fwd_b_sel=3: store data from pc8_M, no register write
    @(negedge clk);
    instr_D = itype(6'h2B, 5, 4, 16'h0004);
    rs_data_D = 32'h100; rt_data_D = 32'h11; ext_imm_D = 32'h4;
    fwd_b_sel = 2'd3; pc8_M = 32'h0000_0ABC;
    edge_sample();
    check("sw_rtfwd", rt_fwd_E, 32'h0000_0ABC);
    check("sw_srcb", SrcB_E, 32'h4);
    check("sw_we", {31'd0, reg_we_E}, 32'd0);

    // lw $9,8($5) writes rt; beq writes nothing
    @(negedge clk);
    fwd_b_sel = 2'd0;
    instr_D = itype(6'h23, 5, 9, 16'h0008); ext_imm_D = 32'h8;
    edge_sample();
    check("lw_wa", {27'd0, wa_E}, 32'd9);
    check("lw_srcb", SrcB_E, 32'h8);
    check("lw_we", {31'd0, reg_we_E}, 32'd1);
    @(negedge clk);
    instr_D = itype(6'h04, 1, 2, 16'h0003);
    edge_sample();
    check("beq_wa", {27'd0, wa_E}, 32'd0);
    check("beq_we", {31'd0, reg_we_E}, 32'd0);

    // hold then clr: bubble at the clr edge
    @(negedge clk);
    instr_D = rtype(1, 2, 11, 6'h21);
    edge_sample();
    @(negedge clk); hold_E = 1'b1; instr_D = rtype(1, 2, 12, 6'h21);
    edge_sample();
    check("hold2_wa", {27'd0, wa_E}, 32'd11);
    @(negedge clk); hold_E = 1'b0; clr_E = 1'b1;
    edge_sample();
    check("holdclr_instr", instr_E, 32'h0);

    // reset overrides hold
    @(negedge clk); clr_E = 1'b0;
    edge_sample();
    check("reload_wa", {27'd0, wa_E}, 32'd12);
    @(negedge clk); hold_E = 1'b1; reset = 1'b0;
    edge_sample();
    check("rsthold_instr", instr_E, 32'h0);
    check("rsthold_pc8", pc8_E, 32'h0000_3000);
    check("rsthold_we", {31'd0, reg_we_E}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
